uart_frame_sequencer: RTL and testbench

//   Parametrised UART frame bit sequencer. Tracks position inside one serial frame: start, N data bits, optional parity, 1 or 2 stops.

---
 rtl/uart_frame_sequencer_if.sv | 39 +++
 rtl/uart_frame_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_uart_frame_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// uart_frame_sequencer_if
//   Bundles the control and status signals of uart_frame_sequencer.
//   master : the TX/RX datapath that issues ticks and frame requests.
//   slave  : the sequencer itself.
//   Signals:
//     en, start, abort               tick strobe, frame request, frame cancel
//     data_len, parity_en, two_stop  per-frame configuration (latched at start)
//     busy, phase, bit_idx           frame position
//     bit_adv, sample, done          1-cycle strobes
// ---------------------------------------------------------------------------
interface uart_frame_sequencer_if #(
   parameter int MAX_DATA_BITS = 9
);
   localparam int IDX_W = (MAX_DATA_BITS > 1) ? $clog2(MAX_DATA_BITS) : 1;

   logic             en;
   logic             start;
   logic             abort;
   logic [3:0]       data_len;
   logic             parity_en;
   logic             two_stop;
   logic             busy;
   logic [2:0]       phase;
   logic [IDX_W-1:0] bit_idx;
   logic             bit_adv;
   logic             sample;
   logic             done;

   modport master (
      output en, start, abort, data_len, parity_en, two_stop,
      input  busy, phase, bit_idx, bit_adv, sample, done
   );

   modport slave (
      input  en, start, abort, data_len, parity_en, two_stop,
      output busy, phase, bit_idx, bit_adv, sample, done
   );
endinterface

// File: rtl/uart_frame_sequencer.sv
// ---------------------------------------------------------------------------
// uart_frame_sequencer
//   Tracks the position inside one UART serial frame: start bit, 1..N data
//   bits, optional parity bit, one or two stop bits. Shared by TX and RX.
//   Configuration macro: UART_OVERSAMPLE_EN
//     undefined : each en pulse is one bit period, sample == bit_adv.
//     defined   : en is an oversample tick; OVS ticks per bit, sample at the
//                 mid-bit tick, bit boundary on the OVS-th tick.
//   Ports:
//     clk    clock
//     reset  synchronous, active-high reset
//     bus    uart_frame_sequencer_if.slave (control in, status/strobes out)
//   All outputs are registered.
// ---------------------------------------------------------------------------
module uart_frame_sequencer #(
   parameter int MAX_DATA_BITS = 9,
   parameter int OVS           = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   uart_frame_sequencer_if.slave        bus
);
   localparam int IDX_W = (MAX_DATA_BITS > 1) ? $clog2(MAX_DATA_BITS) : 1;

   if (MAX_DATA_BITS < 1 || MAX_DATA_BITS > 15) begin : g_len_check
      $error("uart_frame_sequencer: MAX_DATA_BITS must be 1..15");
   end
   if (OVS < 4 || (OVS & (OVS - 1)) != 0) begin : g_ovs_check
      $error("uart_frame_sequencer: OVS must be a power of 2 and >= 4");
   end

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } phase_t;

   phase_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] last_q, last_d;     // clamped data length minus one
   logic             par_q, par_d;
   logic             two_q, two_d;
   logic             stop_q, stop_d;     // set after the first of two stops
   logic             adv_q, adv_d;
   logic             smp_q, smp_d;
   logic             done_q, done_d;
   logic [IDX_W-1:0] last_in;
   logic             boundary;
   logic             mid;

`ifdef UART_OVERSAMPLE_EN
   localparam int SUB_W = $clog2(OVS);
   logic [SUB_W-1:0] sub_q, sub_d;

   assign boundary = (sub_q == SUB_W'(OVS - 1));
   assign mid      = (sub_q == SUB_W'(OVS / 2 - 1));
`else
   assign boundary = 1'b1;
   assign mid      = 1'b1;
`endif

   // Clamp requested length into 1..MAX_DATA_BITS, stored as index of last bit.
   always_comb begin
      last_in = '0;
      if (bus.data_len == 4'd0)
         last_in = '0;
      else if (int'(bus.data_len) > MAX_DATA_BITS)
         last_in = IDX_W'(MAX_DATA_BITS - 1);
      else
         last_in = IDX_W'(int'(bus.data_len) - 1);
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      par_d   = par_q;
      two_d   = two_q;
      stop_d  = stop_q;
      adv_d   = 1'b0;
      smp_d   = 1'b0;
      done_d  = 1'b0;
`ifdef UART_OVERSAMPLE_EN
      sub_d   = sub_q;
`endif
      // abort outranks start, so an abort in IDLE also swallows a start
      if (bus.abort) begin
         state_d = IDLE;
         idx_d   = '0;
         stop_d  = 1'b0;
`ifdef UART_OVERSAMPLE_EN
         sub_d   = '0;
`endif
      end else if (state_q == IDLE) begin
         if (bus.start) begin
            state_d = START;
            idx_d   = '0;
            stop_d  = 1'b0;
            last_d  = last_in;
            par_d   = bus.parity_en;
            two_d   = bus.two_stop;
`ifdef UART_OVERSAMPLE_EN
            sub_d   = '0;
`endif
         end
      end else if (bus.en) begin
`ifdef UART_OVERSAMPLE_EN
         sub_d = sub_q + 1'b1;           // wraps to 0 on the boundary tick
`endif
         smp_d = mid;
         if (boundary) begin
            adv_d = 1'b1;
            unique case (state_q)
               START: begin
                  state_d = DATA;
                  idx_d   = '0;
               end
               DATA: begin
                  if (idx_q == last_q) begin
                     idx_d   = '0;
                     state_d = par_q ? PARITY : STOP;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
               PARITY: state_d = STOP;
               STOP: begin
                  if (two_q && !stop_q) begin
                     stop_d = 1'b1;
                  end else begin
                     stop_d  = 1'b0;
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         last_q  <= '0;
         par_q   <= 1'b0;
         two_q   <= 1'b0;
         stop_q  <= 1'b0;
         adv_q   <= 1'b0;
         smp_q   <= 1'b0;
         done_q  <= 1'b0;
`ifdef UART_OVERSAMPLE_EN
         sub_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         par_q   <= par_d;
         two_q   <= two_d;
         stop_q  <= stop_d;
         adv_q   <= adv_d;
         smp_q   <= smp_d;
         done_q  <= done_d;
`ifdef UART_OVERSAMPLE_EN
         sub_q   <= sub_d;
`endif
      end
   end

   assign bus.busy    = (state_q != IDLE);
   assign bus.phase   = state_q;
   assign bus.bit_idx = idx_q;
   assign bus.bit_adv = adv_q;
   assign bus.sample  = smp_q;
   assign bus.done    = done_q;
endmodule

// File: tb/tb_uart_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_sequencer
//   Drives randomized frames into uart_frame_sequencer and compares every
//   output cycle against a per-bit-period list of expected phases built from
//   the frame rules (start, data bits, parity, stops).
// ---------------------------------------------------------------------------
module tb_uart_frame_sequencer;
   localparam int MAXB  = 9;
   localparam int OVS   = 16;
   localparam int IDX_W = $clog2(MAXB);
`ifdef UART_OVERSAMPLE_EN
   localparam int TPB = OVS;
`else
   localparam int TPB = 1;
`endif

   typedef struct {
      int ph;
      int idx;
   } bit_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   uart_frame_sequencer_if #(.MAX_DATA_BITS(MAXB)) bus ();

   uart_frame_sequencer #(.MAX_DATA_BITS(MAXB), .OVS(OVS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Inputs are changed #1 after a rising edge and outputs are read there too.
   task automatic idle_inputs();
      bus.en        = 1'b0;
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.data_len  = 4'd0;
      bus.parity_en = 1'b0;
      bus.two_stop  = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      checks++;
      if ({bus.busy, bus.phase, bus.bit_idx, bus.bit_adv, bus.sample, bus.done} !== '0) begin
         errors++;
         $display("FAIL reset_state got busy=%b phase=%0d idx=%0d adv=%b smp=%b done=%b want all 0",
                  bus.busy, bus.phase, bus.bit_idx, bus.bit_adv, bus.sample, bus.done);
      end
   endtask

   // Runs one whole frame; ends in the cycle where done is visible so a caller
   // can raise start immediately for a gapless next frame.
   task automatic run_frame(input int len_raw, input bit par, input bit two,
                            input bit en_with_start, input bit poke_start,
                            input int max_gap, output int en_to_done);
      bit_t             q[$];
      int               eff, n, cnt, gaps;
      bit               last;
      logic [2:0]       eph;
      logic [IDX_W-1:0] eidx;
      logic             eadv, esmp, edone, ebusy;

      eff = (len_raw == 0) ? 1 : ((len_raw > MAXB) ? MAXB : len_raw);
      q.push_back('{1, 0});
      for (int i = 0; i < eff; i++) q.push_back('{2, i});
      if (par) q.push_back('{3, 0});
      q.push_back('{4, 0});
      if (two) q.push_back('{4, 0});
      n          = q.size();
      cnt        = 0;
      en_to_done = -1;

      bus.data_len  = 4'(len_raw);
      bus.parity_en = par;
      bus.two_stop  = two;
      bus.start     = 1'b1;
      bus.en        = en_with_start;
      cyc();
      bus.start     = 1'b0;
      bus.en        = 1'b0;
      // config must already be latched; scramble the inputs
      bus.data_len  = 4'($urandom);
      bus.parity_en = 1'($urandom);
      bus.two_stop  = 1'($urandom);
      checks++;
      if (bus.busy !== 1'b1 || bus.phase !== 3'd1 || bus.bit_idx !== '0 ||
          bus.bit_adv !== 1'b0 || bus.done !== 1'b0 || bus.sample !== 1'b0) begin
         errors++;
         $display("FAIL frame_start got busy=%b phase=%0d idx=%0d adv=%b done=%b smp=%b want 1 1 0 0 0 0",
                  bus.busy, bus.phase, bus.bit_idx, bus.bit_adv, bus.done, bus.sample);
      end

      for (int k = 0; k < n; k++) begin
         for (int t = 0; t < TPB; t++) begin
            gaps = $urandom_range(0, max_gap);
            for (int g = 0; g < gaps; g++) begin
               bus.start = poke_start ? 1'($urandom) : 1'b0;
               cyc();
               bus.start = 1'b0;
               checks++;
               if (bus.phase !== 3'(q[k].ph) || bus.bit_idx !== IDX_W'(q[k].idx) ||
                   bus.bit_adv !== 1'b0 || bus.sample !== 1'b0 || bus.done !== 1'b0) begin
                  errors++;
                  $display("FAIL gap_hold len=%0d bit=%0d got phase=%0d idx=%0d adv=%b smp=%b done=%b want phase=%0d idx=%0d strobes 0",
                           len_raw, k, bus.phase, bus.bit_idx, bus.bit_adv, bus.sample, bus.done,
                           q[k].ph, q[k].idx);
               end
            end
            bus.en    = 1'b1;
            bus.start = poke_start ? 1'($urandom) : 1'b0;
            cyc();
            bus.en    = 1'b0;
            bus.start = 1'b0;
            cnt++;
            last = (t == TPB - 1);
            if (last && k + 1 < n) begin
               eph  = 3'(q[k+1].ph);
               eidx = IDX_W'(q[k+1].idx);
            end else if (last) begin
               eph  = 3'd0;
               eidx = '0;
            end else begin
               eph  = 3'(q[k].ph);
               eidx = IDX_W'(q[k].idx);
            end
            eadv  = last;
            esmp  = (TPB == 1) ? last : (t == TPB / 2 - 1);
            edone = last && (k == n - 1);
            ebusy = (eph != 3'd0);
            checks++;
            if (bus.phase !== eph || bus.bit_idx !== eidx || bus.bit_adv !== eadv ||
                bus.sample !== esmp || bus.done !== edone || bus.busy !== ebusy) begin
               errors++;
               $display("FAIL tick len=%0d par=%0d two=%0d bit=%0d tick=%0d got ph=%0d idx=%0d adv=%b smp=%b done=%b busy=%b want ph=%0d idx=%0d adv=%b smp=%b done=%b busy=%b",
                        len_raw, par, two, k, t, bus.phase, bus.bit_idx, bus.bit_adv, bus.sample,
                        bus.done, bus.busy, eph, eidx, eadv, esmp, edone, ebusy);
            end
            if (bus.done === 1'b1 && en_to_done < 0) en_to_done = cnt;
         end
      end
   endtask

   task automatic test_8n1();
      int n;
      run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 0, n);
      checks++;
      if (n !== 10 * TPB) begin
         errors++;
         $display("FAIL len_8n1 got %0d en to done want %0d", n, 10 * TPB);
      end
      cyc();
   endtask

   task automatic test_7e2();
      int n;
      run_frame(7, 1'b1, 1'b1, 1'b0, 1'b0, 1, n);
      checks++;
      if (n !== 11 * TPB) begin
         errors++;
         $display("FAIL len_7e2 got %0d en to done want %0d", n, 11 * TPB);
      end
      cyc();
   endtask

   task automatic test_start_rules();
      int n;
      run_frame(8, 1'b0, 1'b0, 1'b1, 1'b1, 1, n);
      checks++;
      if (n !== 10 * TPB) begin
         errors++;
         $display("FAIL start_en_same got %0d en to done want %0d", n, 10 * TPB);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      int n;
      run_frame(5, 1'b0, 1'b0, 1'b0, 1'b0, 0, n);
      run_frame(9, 1'b1, 1'b0, 1'b0, 1'b0, 0, n);
      checks++;
      if (n !== 12 * TPB) begin
         errors++;
         $display("FAIL b2b_second got %0d en to done want %0d", n, 12 * TPB);
      end
      run_frame(1, 1'b0, 1'b1, 1'b0, 1'b0, 0, n);
      checks++;
      if (n !== 4 * TPB) begin
         errors++;
         $display("FAIL b2b_third got %0d en to done want %0d", n, 4 * TPB);
      end
      cyc();
   endtask

   task automatic test_abort();
      bus.abort = 1'b1;
      cyc();
      bus.abort = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.phase !== 3'd0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle got busy=%b phase=%0d done=%b want 0 0 0", bus.busy, bus.phase, bus.done);
      end
      for (int pass = 0; pass < 2; pass++) begin
         bus.data_len = 4'd8;
         bus.start    = 1'b1;
         cyc();
         bus.start = 1'b0;
         for (int i = 0; i < 3; i++) begin
            bus.en = 1'b1;
            cyc();
            bus.en = 1'b0;
         end
         // fourth en coincides with the cancel; it must not produce a boundary
         bus.en = 1'b1;
         if (pass == 0) bus.abort = 1'b1;
         else reset = 1'b1;
         cyc();
         bus.en    = 1'b0;
         bus.abort = 1'b0;
         reset     = 1'b0;
         checks++;
         if (bus.busy !== 1'b0 || bus.phase !== 3'd0 || bus.bit_idx !== '0 ||
             bus.bit_adv !== 1'b0 || bus.done !== 1'b0 || bus.sample !== 1'b0) begin
            errors++;
            $display("FAIL cancel_%s got busy=%b phase=%0d idx=%0d adv=%b done=%b smp=%b want all 0",
                     (pass == 0) ? "abort" : "reset", bus.busy, bus.phase, bus.bit_idx,
                     bus.bit_adv, bus.done, bus.sample);
         end
         for (int i = 0; i < 2 * TPB + 2; i++) begin
            bus.en = 1'b1;
            cyc();
            bus.en = 1'b0;
            checks++;
            if (bus.busy !== 1'b0 || bus.bit_adv !== 1'b0 || bus.done !== 1'b0) begin
               errors++;
               $display("FAIL idle_en got busy=%b adv=%b done=%b want 0 0 0", bus.busy, bus.bit_adv, bus.done);
            end
         end
      end
   endtask

   task automatic test_clamp();
      int n;
      run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, 0, n);
      checks++;
      if (n !== 3 * TPB) begin
         errors++;
         $display("FAIL clamp_len0 got %0d en to done want %0d", n, 3 * TPB);
      end
      run_frame(12, 1'b0, 1'b0, 1'b0, 1'b0, 0, n);
      checks++;
      if (n !== 11 * TPB) begin
         errors++;
         $display("FAIL clamp_len12 got %0d en to done want %0d", n, 11 * TPB);
      end
      cyc();
   endtask

   task automatic test_random();
      int  n, len;
      bit  par, two;
      for (int f = 0; f < 12; f++) begin
         len = $urandom_range(0, 15);
         par = 1'($urandom);
         two = 1'($urandom);
         run_frame(len, par, two, 1'($urandom), 1'($urandom), 2, n);
         checks++;
         if (n !== (2 + ((len == 0) ? 1 : ((len > MAXB) ? MAXB : len)) + int'(par) + int'(two)) * TPB) begin
            errors++;
            $display("FAIL rand_len len=%0d par=%0d two=%0d got %0d en to done", len, par, two, n);
         end
         if ($urandom_range(0, 1) == 1) cyc();
      end
      cyc();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_8n1();
      test_7e2();
      test_start_rules();
      test_back_to_back();
      test_abort();
      test_clamp();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
